lh_table_arb: RTL and testbench
===============================

# lh_table_arb

- Owns the write port and shares the read port of the per-FID logic-hash / serial-number / PPL tables.
- Sequences the zero-fill of the tables after reset and on software clear.
- Merges ECDSA table updates with host PIO reads and writes.
- Gives the packet datapath unstalled priority on the table read port.

## Interface
Parameters:
- FID_NBITS, default `FID_NBITS: table address width; table depth is 2^FID_NBITS.
- LH_NBITS, default `LOGIC_HASH_NBITS: logic-hash field width.
- SN_NBITS, default `SERIAL_NUM_NBITS: serial-number field width.
- PPL_NBITS, default `PPL_NBITS: PPL field width.
- Derived: ENT_NBITS = PPL_NBITS+SN_NBITS+LH_NBITS. Entry layout is {ppl, sn, lh}, MSB first.

Ports:
- clk  in  1  sole clock.
- `RESET_SIG  in  1  synchronous, active-high reset.
- ecdsa_lh_wr  in  1  ECDSA update strobe. No backpressure; at most one per cycle.
- ecdsa_lh_waddr  in  FID_NBITS  update address.
- ecdsa_lh_wdata  in  LH_NBITS  update logic hash.
- ecdsa_lh_sn_wdata  in  SN_NBITS  update serial number.
- ecdsa_lh_ppl_wdata  in  PPL_NBITS  update PPL.
- dp_rd  in  1  datapath table read.
- dp_raddr  in  FID_NBITS  datapath read address.
- pio_req  in  1  host request; held until pio_ack.
- pio_we  in  1  1 = write, 0 = read.
- pio_addr  in  FID_NBITS  host address.
- pio_wdata  in  ENT_NBITS  host write entry.
- pio_ack  out  1  single-cycle completion pulse.
- pio_rdata  out  ENT_NBITS  read entry; valid with pio_ack.
- clr_req  in  1  pulse: restart table zero-fill.
- tbl_wr  out  1  table write enable.
- tbl_waddr  out  FID_NBITS  table write address.
- tbl_wdata  out  ENT_NBITS  table write entry.
- tbl_rd  out  1  table read enable.
- tbl_raddr  out  FID_NBITS  table read address.
- tbl_rdata  in  ENT_NBITS  table read data; 1-cycle RAM latency.
- init_done  out  1  high once the tables are zeroed.
- drop_cnt  out  8  saturating count of dropped ECDSA updates.

## Operation
State machine, three states:
- S_INIT
  - Each cycle writes zero to init_cnt, then increments init_cnt.
  - After writing address 2^FID_NBITS-1, goes to S_RUN and sets init_done.
  - ECDSA updates arriving in S_INIT are dropped and drop_cnt is incremented.
  - pio_req is not sampled.
  - A clr_req in S_INIT resets init_cnt to 0; the fill restarts.
- S_RUN, write port:
  - ecdsa_lh_wr has priority over a PIO write.
  - A PIO write is accepted only when ecdsa_lh_wr=0.
  - A losing PIO write stays pending; it is never dropped.
- S_RUN, read port:
  - dp_rd always wins and passes through combinationally: tbl_rd=1, tbl_raddr=dp_raddr.
  - A PIO read is issued only in a cycle with dp_rd=0; the block then goes to S_PRD.
- S_PRD
  - Captures tbl_rdata into pio_rdata and pulses pio_ack.
  - Returns to S_RUN.
- Request sampling:
  - pio_req is ignored in the cycle pio_ack=1, so a level request is not re-executed.
  - The requester drops pio_req or presents a new request after that cycle.
- clr_req handling:
  - In S_RUN: go to S_INIT, clear init_done, set init_cnt=0.
  - In S_PRD: latched and taken on return to S_RUN, after the read completes.
  - A clr_req coincident with an accepted PIO write: the write completes (ack issued), then S_INIT.
- drop_cnt saturates at 255 and clears only on reset.

## Timing
- Reset values:
  - State S_INIT, init_cnt=0, init_done=0.
  - tbl_wr=0, tbl_waddr=0, tbl_wdata=0.
  - pio_ack=0, pio_rdata=0, drop_cnt=0.
  - Pending clr cleared.
- tbl_rd and tbl_raddr are combinational. Reset value: dp_rd passthrough.
- Write-port outputs are registered.
  - The first init write (address 0) appears in the first cycle after reset deasserts.
  - The fill takes 2^FID_NBITS consecutive cycles; init_done rises the cycle after the last write.
- ECDSA update sampled at cycle T appears as tbl_wr at T+1.
- PIO write accepted at T: tbl_wr and pio_ack both at T+1.
- PIO read issued at T: tbl_rdata is valid at T+1; pio_ack and pio_rdata are registered at T+2.
- A PIO read is delayed only while dp_rd is held high. Latency is 2 + (number of consecutive dp_rd cycles).
- Reset mid-operation:
  - An outstanding PIO request is abandoned with no ack; the host reissues.
  - The zero-fill restarts from address 0.

## Test plan
- Reset and init, FID_NBITS=4:
  - Reset release -> 16 consecutive tbl_wr with waddr 0..15 and wdata=0.
  - init_done=1 on cycle 17; no other writes.
- ECDSA during init:
  - 3 ecdsa_lh_wr pulses in S_INIT -> no tbl_wr carries their data; drop_cnt=3.
  - 300 pulses -> drop_cnt=255.
- Write collision:
  - pio write addr 5 with ecdsa_lh_wr to addr 9 held for 3 cycles -> three tbl_wr to 9.
  - Then tbl_wr to 5 with pio_wdata; a single pio_ack, coincident with the addr-5 write.
- PIO read vs datapath:
  - pio read addr 7 while dp_rd is held 4 cycles -> tbl_raddr=dp_raddr for 4 cycles, then 7.
  - pio_ack 2 cycles later; pio_rdata equals the tbl_rdata returned for addr 7.
- Clear during read:
  - clr_req in the issue cycle of a PIO read -> the read completes with ack.
  - Then init_done drops and 16 zero writes from address 0 follow.
- Mid-fill reset:
  - Assert reset at init_cnt=10 -> all outputs at reset values; refill starts at address 0.

Source files
------------

// File: rtl/lh_table_arb.sv
// lh_table_arb: arbiter for the per-FID logic-hash / serial-number / PPL tables.
// Owns the table write port (zero-fill, ECDSA updates, host PIO writes) and
// shares the read port between the packet datapath and host PIO reads.
//
// state  | meaning
// -------+----------------------------------------------------------------
// S_INIT | zero-filling the tables; ECDSA updates dropped, PIO ignored
// S_RUN  | normal operation; ECDSA over PIO writes, datapath over PIO reads
// S_PRD  | PIO read in flight; capture RAM data and acknowledge

`ifndef FID_NBITS
`define FID_NBITS 4
`endif
`ifndef LOGIC_HASH_NBITS
`define LOGIC_HASH_NBITS 16
`endif
`ifndef SERIAL_NUM_NBITS
`define SERIAL_NUM_NBITS 8
`endif
`ifndef PPL_NBITS
`define PPL_NBITS 8
`endif

module lh_table_arb #(
  parameter int FID_NBITS = `FID_NBITS,
  parameter int LH_NBITS  = `LOGIC_HASH_NBITS,
  parameter int SN_NBITS  = `SERIAL_NUM_NBITS,
  parameter int PPL_NBITS = `PPL_NBITS,
  localparam int ENT_NBITS = PPL_NBITS + SN_NBITS + LH_NBITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ecdsa_lh_wr,
  input  logic [FID_NBITS-1:0] ecdsa_lh_waddr,
  input  logic [LH_NBITS-1:0]  ecdsa_lh_wdata,
  input  logic [SN_NBITS-1:0]  ecdsa_lh_sn_wdata,
  input  logic [PPL_NBITS-1:0] ecdsa_lh_ppl_wdata,
  input  logic                 dp_rd,
  input  logic [FID_NBITS-1:0] dp_raddr,
  input  logic                 pio_req,
  input  logic                 pio_we,
  input  logic [FID_NBITS-1:0] pio_addr,
  input  logic [ENT_NBITS-1:0] pio_wdata,
  output logic                 pio_ack,
  output logic [ENT_NBITS-1:0] pio_rdata,
  input  logic                 clr_req,
  output logic                 tbl_wr,
  output logic [FID_NBITS-1:0] tbl_waddr,
  output logic [ENT_NBITS-1:0] tbl_wdata,
  output logic                 tbl_rd,
  output logic [FID_NBITS-1:0] tbl_raddr,
  input  logic [ENT_NBITS-1:0] tbl_rdata,
  output logic                 init_done,
  output logic [7:0]           drop_cnt
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_PRD  = 2'd2
  } state_t;

  state_t               state;
  // One extra bit: the MSB marks "every address has been written".
  logic [FID_NBITS:0]   init_cnt;
  logic                 clr_pend;

  logic                 pio_take;
  logic                 pio_rd_issue;
  logic                 pio_wr_take;
  logic [ENT_NBITS-1:0] ecdsa_ent;

  // Request qualification and the combinational read-port mux.
  // The request is ignored during the ack cycle so a held level is not re-run.
  always_comb begin
    ecdsa_ent    = {ecdsa_lh_ppl_wdata, ecdsa_lh_sn_wdata, ecdsa_lh_wdata};
    pio_take     = pio_req && !pio_ack;
    pio_rd_issue = !rst && (state == S_RUN) && pio_take && !pio_we && !dp_rd;
    pio_wr_take  = (state == S_RUN) && pio_take && pio_we && !ecdsa_lh_wr;
    tbl_rd       = dp_rd || pio_rd_issue;
    tbl_raddr    = pio_rd_issue ? pio_addr : dp_raddr;
  end

  // Sequencer: zero-fill, write-port arbitration, PIO read completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
      clr_pend  <= 1'b0;
      tbl_wr    <= 1'b0;
      tbl_waddr <= '0;
      tbl_wdata <= '0;
      pio_ack   <= 1'b0;
      pio_rdata <= '0;
      drop_cnt  <= '0;
    end else begin
      tbl_wr  <= 1'b0;
      pio_ack <= 1'b0;
      case (state)
        S_INIT: begin
          if (ecdsa_lh_wr && (drop_cnt != 8'hff)) begin
            drop_cnt <= drop_cnt + 8'd1;
          end
          if (clr_req) begin
            init_cnt <= '0;
          end else if (!init_cnt[FID_NBITS]) begin
            tbl_wr    <= 1'b1;
            tbl_waddr <= init_cnt[FID_NBITS-1:0];
            tbl_wdata <= '0;
            init_cnt  <= init_cnt + 1'b1;
          end else begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end
        end

        S_RUN: begin
          if (ecdsa_lh_wr) begin
            tbl_wr    <= 1'b1;
            tbl_waddr <= ecdsa_lh_waddr;
            tbl_wdata <= ecdsa_ent;
          end else if (pio_wr_take) begin
            tbl_wr    <= 1'b1;
            tbl_waddr <= pio_addr;
            tbl_wdata <= pio_wdata;
            pio_ack   <= 1'b1;
          end
          // A read being issued finishes first; the clear waits in clr_pend.
          if (pio_rd_issue) begin
            state    <= S_PRD;
            clr_pend <= clr_req;
          end else if (clr_req) begin
            state     <= S_INIT;
            init_done <= 1'b0;
            init_cnt  <= '0;
          end
        end

        S_PRD: begin
          if (ecdsa_lh_wr) begin
            tbl_wr    <= 1'b1;
            tbl_waddr <= ecdsa_lh_waddr;
            tbl_wdata <= ecdsa_ent;
          end
          pio_rdata <= tbl_rdata;
          pio_ack   <= 1'b1;
          if (clr_pend || clr_req) begin
            state     <= S_INIT;
            init_done <= 1'b0;
            init_cnt  <= '0;
            clr_pend  <= 1'b0;
          end else begin
            state <= S_RUN;
          end
        end

        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lh_table_arb.sv
// Bench for lh_table_arb: directed scenarios plus randomized PIO/ECDSA/datapath
// traffic checked against a shadow table and timing rules kept in the bench.
module tb_lh_table_arb;
  localparam int FID = 4;
  localparam int LH  = 16;
  localparam int SN  = 8;
  localparam int PPL = 8;
  localparam int ENT = PPL + SN + LH;
  localparam int DEPTH = 1 << FID;

  logic           clk, rst;
  logic           ecdsa_lh_wr;
  logic [FID-1:0] ecdsa_lh_waddr;
  logic [LH-1:0]  ecdsa_lh_wdata;
  logic [SN-1:0]  ecdsa_lh_sn_wdata;
  logic [PPL-1:0] ecdsa_lh_ppl_wdata;
  logic           dp_rd;
  logic [FID-1:0] dp_raddr;
  logic           pio_req, pio_we;
  logic [FID-1:0] pio_addr;
  logic [ENT-1:0] pio_wdata;
  logic           pio_ack;
  logic [ENT-1:0] pio_rdata;
  logic           clr_req;
  logic           tbl_wr;
  logic [FID-1:0] tbl_waddr;
  logic [ENT-1:0] tbl_wdata;
  logic           tbl_rd;
  logic [FID-1:0] tbl_raddr;
  logic [ENT-1:0] tbl_rdata;
  logic           init_done;
  logic [7:0]     drop_cnt;

  int checks = 0;
  int failures = 0;
  logic [ENT-1:0] mem [DEPTH];
  logic [ENT-1:0] shadow [DEPTH];

  lh_table_arb #(.FID_NBITS(FID), .LH_NBITS(LH), .SN_NBITS(SN), .PPL_NBITS(PPL)) dut (
    .clk(clk), .rst(rst),
    .ecdsa_lh_wr(ecdsa_lh_wr), .ecdsa_lh_waddr(ecdsa_lh_waddr),
    .ecdsa_lh_wdata(ecdsa_lh_wdata), .ecdsa_lh_sn_wdata(ecdsa_lh_sn_wdata),
    .ecdsa_lh_ppl_wdata(ecdsa_lh_ppl_wdata),
    .dp_rd(dp_rd), .dp_raddr(dp_raddr),
    .pio_req(pio_req), .pio_we(pio_we), .pio_addr(pio_addr), .pio_wdata(pio_wdata),
    .pio_ack(pio_ack), .pio_rdata(pio_rdata), .clr_req(clr_req),
    .tbl_wr(tbl_wr), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata),
    .tbl_rd(tbl_rd), .tbl_raddr(tbl_raddr), .tbl_rdata(tbl_rdata),
    .init_done(init_done), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table RAM: one-cycle read latency, read-before-write.
  always @(posedge clk) begin
    if (tbl_wr) mem[tbl_waddr] <= tbl_wdata;
    if (tbl_rd) tbl_rdata <= mem[tbl_raddr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ecdsa_lh_wr = 0; ecdsa_lh_waddr = '0; ecdsa_lh_wdata = '0;
    ecdsa_lh_sn_wdata = '0; ecdsa_lh_ppl_wdata = '0;
    dp_rd = 0; dp_raddr = '0; pio_req = 0; pio_we = 0; pio_addr = '0;
    pio_wdata = '0; clr_req = 0;
  endtask

  task automatic wait_init(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (init_done === 1'b1) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic pio_write_op(input logic [FID-1:0] a, input logic [ENT-1:0] d, output bit ok);
    pio_req = 1; pio_we = 1; pio_addr = a; pio_wdata = d; ok = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (pio_ack === 1'b1) begin ok = 1; break; end
    end
    pio_req = 0; pio_we = 0;
  endtask

  task automatic pio_read_op(input logic [FID-1:0] a, output logic [ENT-1:0] d, output bit ok);
    pio_req = 1; pio_we = 0; pio_addr = a; ok = 0; d = '0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (pio_ack === 1'b1) begin ok = 1; d = pio_rdata; break; end
    end
    pio_req = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; ecdsa_lh_wr = 1; ecdsa_lh_waddr = 4'd3; pio_req = 1; pio_addr = 4'd3;
    dp_rd = 0; dp_raddr = 4'd6;
    tick(); tick();
    checks++; if (tbl_wr !== 1'b0) begin failures++; $display("FAIL reset_tbl_wr: got %0h exp 0", tbl_wr); end
    checks++; if (tbl_waddr !== 4'd0) begin failures++; $display("FAIL reset_tbl_waddr: got %0h exp 0", tbl_waddr); end
    checks++; if (tbl_wdata !== '0) begin failures++; $display("FAIL reset_tbl_wdata: got %0h exp 0", tbl_wdata); end
    checks++; if (pio_ack !== 1'b0) begin failures++; $display("FAIL reset_pio_ack: got %0h exp 0", pio_ack); end
    checks++; if (pio_rdata !== '0) begin failures++; $display("FAIL reset_pio_rdata: got %0h exp 0", pio_rdata); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done: got %0h exp 0", init_done); end
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop_cnt: got %0h exp 0", drop_cnt); end
    checks++; if (tbl_rd !== 1'b0 || tbl_raddr !== 4'd6) begin failures++; $display("FAIL reset_rd_idle: got rd=%0h addr=%0h exp rd=0 addr=6", tbl_rd, tbl_raddr); end
    dp_rd = 1; dp_raddr = 4'd11; #1;
    checks++; if (tbl_rd !== 1'b1 || tbl_raddr !== 4'd11) begin failures++; $display("FAIL reset_rd_pass: got rd=%0h addr=%0h exp rd=1 addr=b", tbl_rd, tbl_raddr); end
    idle_inputs();
  endtask

  task automatic test_init_fill();
    idle_inputs(); rst = 1; tick(); rst = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k <= DEPTH) begin
        checks++; if (tbl_wr !== 1'b1 || tbl_waddr !== 4'(k-1) || tbl_wdata !== '0) begin failures++;
          $display("FAIL init_fill_write: cycle %0d got wr=%0h addr=%0h data=%0h exp wr=1 addr=%0h data=0", k, tbl_wr, tbl_waddr, tbl_wdata, k-1); end
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL init_fill_done_early: cycle %0d got %0h exp 0", k, init_done); end
      end else begin
        checks++; if (tbl_wr !== 1'b0) begin failures++; $display("FAIL init_fill_extra_write: cycle %0d got wr=%0h exp 0", k, tbl_wr); end
        checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL init_fill_done: cycle %0d got %0h exp 1", k, init_done); end
      end
    end
  endtask

  task automatic test_init_drop();
    int nwr, bad;
    nwr = 0; bad = 0;
    idle_inputs(); rst = 1; tick(); rst = 0;
    for (int k = 0; k < 20; k++) begin
      ecdsa_lh_wr = (k == 1 || k == 3 || k == 5);
      ecdsa_lh_waddr = 4'd3; ecdsa_lh_wdata = 16'hbeef; ecdsa_lh_sn_wdata = 8'h5a; ecdsa_lh_ppl_wdata = 8'ha5;
      tick();
      if (tbl_wr === 1'b1) begin nwr++; if (tbl_wdata !== '0) bad++; end
    end
    idle_inputs();
    checks++; if (nwr != DEPTH) begin failures++; $display("FAIL init_drop_nwr: got %0d exp %0d", nwr, DEPTH); end
    checks++; if (bad != 0) begin failures++; $display("FAIL init_drop_data: got %0d nonzero writes exp 0", bad); end
    checks++; if (drop_cnt !== 8'd3) begin failures++; $display("FAIL init_drop_cnt: got %0d exp 3", drop_cnt); end
    checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL init_drop_done: got %0h exp 1", init_done); end
  endtask

  task automatic test_drop_sat();
    bit ok;
    idle_inputs(); rst = 1; tick(); rst = 0;
    for (int i = 0; i < 300; i++) begin
      if (i == 100) begin
        checks++; if (drop_cnt !== 8'd100) begin failures++; $display("FAIL drop_mid: got %0d exp 100", drop_cnt); end
      end
      ecdsa_lh_wr = 1; clr_req = 1;
      tick();
    end
    idle_inputs();
    checks++; if (drop_cnt !== 8'd255) begin failures++; $display("FAIL drop_sat: got %0d exp 255", drop_cnt); end
    checks++; if (init_done !== 1'b0 || tbl_wr !== 1'b0) begin failures++; $display("FAIL drop_clr_hold: got done=%0h wr=%0h exp 0 0", init_done, tbl_wr); end
    wait_init(ok);
    checks++; if (!ok) begin failures++; $display("FAIL drop_init_timeout: got no init_done exp init_done=1"); end
    checks++; if (drop_cnt !== 8'd255) begin failures++; $display("FAIL drop_sticky: got %0d exp 255", drop_cnt); end
  endtask

  task automatic test_write_collision();
    logic [ENT-1:0] w, exp_d;
    logic [FID-1:0] exp_a;
    bit exp_wr, exp_ack;
    int acks;
    acks = 0; w = $urandom;
    pio_we = 1; pio_addr = 4'd5; pio_wdata = w;
    for (int c = 0; c < 7; c++) begin
      pio_req = (c <= 4);
      ecdsa_lh_wr = (c < 3); ecdsa_lh_waddr = 4'd9;
      ecdsa_lh_wdata = LH'($urandom); ecdsa_lh_sn_wdata = SN'($urandom); ecdsa_lh_ppl_wdata = PPL'($urandom);
      exp_wr = (c <= 3); exp_ack = (c == 3);
      exp_a = (c < 3) ? 4'd9 : 4'd5;
      exp_d = (c < 3) ? {ecdsa_lh_ppl_wdata, ecdsa_lh_sn_wdata, ecdsa_lh_wdata} : w;
      tick();
      if (pio_ack === 1'b1) acks++;
      checks++; if (tbl_wr !== exp_wr) begin failures++; $display("FAIL coll_wr: cycle %0d got %0h exp %0h", c+1, tbl_wr, exp_wr); end
      if (exp_wr) begin
        checks++; if (tbl_waddr !== exp_a || tbl_wdata !== exp_d) begin failures++;
          $display("FAIL coll_wdata: cycle %0d got addr=%0h data=%0h exp addr=%0h data=%0h", c+1, tbl_waddr, tbl_wdata, exp_a, exp_d); end
      end
      checks++; if (pio_ack !== exp_ack) begin failures++; $display("FAIL coll_ack: cycle %0d got %0h exp %0h", c+1, pio_ack, exp_ack); end
    end
    idle_inputs();
    checks++; if (acks != 1) begin failures++; $display("FAIL coll_ack_count: got %0d exp 1", acks); end
  endtask

  task automatic test_pio_read_dp();
    bit ok;
    logic [ENT-1:0] v;
    v = $urandom;
    pio_write_op(4'd7, v, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rd_prewrite_timeout: got no ack exp ack"); end
    tick();
    for (int c = 0; c < 8; c++) begin
      pio_req = (c <= 6); pio_we = 0; pio_addr = 4'd7;
      dp_rd = (c < 4); dp_raddr = FID'($urandom);
      #1;
      if (c < 4) begin
        checks++; if (tbl_rd !== 1'b1 || tbl_raddr !== dp_raddr) begin failures++;
          $display("FAIL rd_dp_pass: cycle %0d got rd=%0h addr=%0h exp rd=1 addr=%0h", c, tbl_rd, tbl_raddr, dp_raddr); end
      end else if (c == 4) begin
        checks++; if (tbl_rd !== 1'b1 || tbl_raddr !== 4'd7) begin failures++;
          $display("FAIL rd_issue: got rd=%0h addr=%0h exp rd=1 addr=7", tbl_rd, tbl_raddr); end
      end else begin
        checks++; if (tbl_rd !== 1'b0) begin failures++; $display("FAIL rd_no_reissue: cycle %0d got rd=%0h exp 0", c, tbl_rd); end
      end
      tick();
      checks++; if (pio_ack !== (c + 1 == 6)) begin failures++; $display("FAIL rd_ack: cycle %0d got %0h exp %0h", c+1, pio_ack, (c + 1 == 6)); end
      if (c + 1 == 6) begin
        checks++; if (pio_rdata !== v) begin failures++; $display("FAIL rd_data: got %0h exp %0h", pio_rdata, v); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_clear_during_read();
    logic [ENT-1:0] v;
    v = mem[7];
    pio_req = 1; pio_we = 0; pio_addr = 4'd7; clr_req = 1; #1;
    checks++; if (tbl_rd !== 1'b1 || tbl_raddr !== 4'd7) begin failures++; $display("FAIL clr_rd_issue: got rd=%0h addr=%0h exp rd=1 addr=7", tbl_rd, tbl_raddr); end
    tick(); clr_req = 0;
    checks++; if (pio_ack !== 1'b0 || init_done !== 1'b1) begin failures++; $display("FAIL clr_rd_wait: got ack=%0h done=%0h exp 0 1", pio_ack, init_done); end
    tick();
    checks++; if (pio_ack !== 1'b1 || pio_rdata !== v) begin failures++; $display("FAIL clr_rd_ack: got ack=%0h data=%0h exp 1 %0h", pio_ack, pio_rdata, v); end
    pio_req = 0;
    for (int k = 3; k <= 19; k++) begin
      tick();
      if (k == 3) begin
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL clr_done_drop: got %0h exp 0", init_done); end
      end
      if (k <= 18) begin
        checks++; if (tbl_wr !== 1'b1 || tbl_waddr !== 4'(k-3) || tbl_wdata !== '0) begin failures++;
          $display("FAIL clr_fill: cycle %0d got wr=%0h addr=%0h data=%0h exp wr=1 addr=%0h data=0", k, tbl_wr, tbl_waddr, tbl_wdata, k-3); end
      end else begin
        checks++; if (init_done !== 1'b1 || tbl_wr !== 1'b0) begin failures++; $display("FAIL clr_fill_end: got done=%0h wr=%0h exp 1 0", init_done, tbl_wr); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_mid_fill_reset();
    pio_req = 1; pio_we = 0; pio_addr = 4'd2;
    tick();
    rst = 1; pio_req = 0;
    tick();
    checks++; if (pio_ack !== 1'b0 || pio_rdata !== '0) begin failures++; $display("FAIL abandon_read: got ack=%0h data=%0h exp 0 0", pio_ack, pio_rdata); end
    rst = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++; if (tbl_wr !== 1'b1 || tbl_waddr !== 4'(k-1)) begin failures++; $display("FAIL mid_fill_pre: cycle %0d got wr=%0h addr=%0h exp 1 %0h", k, tbl_wr, tbl_waddr, k-1); end
    end
    rst = 1; ecdsa_lh_wr = 1; pio_req = 1; pio_we = 1;
    tick();
    checks++; if (tbl_wr !== 1'b0 || tbl_waddr !== 4'd0 || tbl_wdata !== '0) begin failures++; $display("FAIL mid_reset_wport: got wr=%0h addr=%0h data=%0h exp 0 0 0", tbl_wr, tbl_waddr, tbl_wdata); end
    checks++; if (pio_ack !== 1'b0 || pio_rdata !== '0 || init_done !== 1'b0 || drop_cnt !== 8'd0) begin failures++;
      $display("FAIL mid_reset_misc: got ack=%0h rdata=%0h done=%0h drop=%0h exp all 0", pio_ack, pio_rdata, init_done, drop_cnt); end
    idle_inputs(); rst = 0;
    tick();
    checks++; if (tbl_wr !== 1'b1 || tbl_waddr !== 4'd0) begin failures++; $display("FAIL mid_refill_start: got wr=%0h addr=%0h exp 1 0", tbl_wr, tbl_waddr); end
  endtask

  task automatic test_random();
    bit ok, we, done, e, prev_e, dp;
    logic [FID-1:0] addr, prev_ea;
    logic [ENT-1:0] wd, prev_ent, rd;
    int exp_ack_cyc, dp_hold, cyc;
    idle_inputs(); rst = 1; tick(); rst = 0;
    wait_init(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rand_init_timeout: got no init_done exp init_done=1"); end
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    prev_e = 0; prev_ea = '0; prev_ent = '0;
    for (int t = 0; t < 60; t++) begin
      we = $urandom_range(0, 1); addr = FID'($urandom_range(0, 7)); wd = $urandom;
      dp_hold = we ? 0 : $urandom_range(0, 3);
      pio_req = 1; pio_we = we; pio_addr = addr; pio_wdata = wd;
      exp_ack_cyc = -1; done = 0; cyc = 0;
      while (!done && cyc < 40) begin
        if (cyc == exp_ack_cyc) begin
          done = 1;
          checks++; if (pio_ack !== 1'b1) begin failures++; $display("FAIL rand_ack: txn %0d got %0h exp 1", t, pio_ack); end
          if (we) begin
            checks++; if (tbl_wr !== 1'b1 || tbl_waddr !== addr || tbl_wdata !== wd) begin failures++;
              $display("FAIL rand_pio_write: txn %0d got wr=%0h addr=%0h data=%0h exp 1 %0h %0h", t, tbl_wr, tbl_waddr, tbl_wdata, addr, wd); end
          end else begin
            checks++; if (pio_rdata !== shadow[addr]) begin failures++; $display("FAIL rand_pio_read: txn %0d addr %0h got %0h exp %0h", t, addr, pio_rdata, shadow[addr]); end
          end
        end else begin
          checks++; if (pio_ack !== 1'b0) begin failures++; $display("FAIL rand_spurious_ack: txn %0d cyc %0d got 1 exp 0", t, cyc); end
        end
        if (prev_e) begin
          checks++; if (tbl_wr !== 1'b1 || tbl_waddr !== prev_ea || tbl_wdata !== prev_ent) begin failures++;
            $display("FAIL rand_ecdsa: got wr=%0h addr=%0h data=%0h exp 1 %0h %0h", tbl_wr, tbl_waddr, tbl_wdata, prev_ea, prev_ent); end
        end else if (!(done && we)) begin
          checks++; if (tbl_wr !== 1'b0) begin failures++; $display("FAIL rand_idle_write: txn %0d cyc %0d got 1 exp 0", t, cyc); end
        end
        e = $urandom_range(0, 1);
        ecdsa_lh_wr = e; ecdsa_lh_waddr = FID'($urandom_range(8, 15));
        ecdsa_lh_wdata = LH'($urandom); ecdsa_lh_sn_wdata = SN'($urandom); ecdsa_lh_ppl_wdata = PPL'($urandom);
        if (e) shadow[ecdsa_lh_waddr] = {ecdsa_lh_ppl_wdata, ecdsa_lh_sn_wdata, ecdsa_lh_wdata};
        if (!we && exp_ack_cyc < 0) dp = (cyc < dp_hold);
        else dp = $urandom_range(0, 1);
        dp_rd = dp; dp_raddr = FID'($urandom);
        #1;
        if (!we && exp_ack_cyc < 0) begin
          checks++; if (tbl_rd !== 1'b1 || tbl_raddr !== (dp ? dp_raddr : addr)) begin failures++;
            $display("FAIL rand_rd_port: txn %0d got rd=%0h addr=%0h exp 1 %0h", t, tbl_rd, tbl_raddr, dp ? dp_raddr : addr); end
          if (!dp) exp_ack_cyc = cyc + 2;
        end else begin
          checks++; if (tbl_rd !== dp || (dp && tbl_raddr !== dp_raddr)) begin failures++;
            $display("FAIL rand_rd_pass: txn %0d got rd=%0h addr=%0h exp %0h %0h", t, tbl_rd, tbl_raddr, dp, dp_raddr); end
          if (we && !done && exp_ack_cyc < 0 && !e) begin
            exp_ack_cyc = cyc + 1; shadow[addr] = wd;
          end
        end
        prev_e = e; prev_ea = ecdsa_lh_waddr; prev_ent = {ecdsa_lh_ppl_wdata, ecdsa_lh_sn_wdata, ecdsa_lh_wdata};
        tick();
        cyc++;
      end
      checks++; if (!done) begin failures++; $display("FAIL rand_timeout: txn %0d got no ack within 40 cycles exp ack", t); end
      if (!done) break;
    end
    idle_inputs();
    if (prev_e) begin
      checks++; if (tbl_wr !== 1'b1 || tbl_waddr !== prev_ea || tbl_wdata !== prev_ent) begin failures++;
        $display("FAIL rand_ecdsa_last: got wr=%0h addr=%0h data=%0h exp 1 %0h %0h", tbl_wr, tbl_waddr, tbl_wdata, prev_ea, prev_ent); end
    end
    tick(); tick();
    for (int a = 0; a < DEPTH; a++) begin
      pio_read_op(FID'(a), rd, ok);
      checks++; if (!ok || rd !== shadow[a]) begin failures++; $display("FAIL rand_sweep: addr %0h ack=%0d got %0h exp %0h", a, ok, rd, shadow[a]); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_init_fill();
    test_init_drop();
    test_drop_sat();
    test_write_collision();
    test_pio_read_dp();
    test_clear_during_read();
    test_mid_fill_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
